fifo_burst_rd: RTL

FIFO_BURST_RD -- requirements
Module: fifo_burst_rd

---
 rtl/fifo_burst_rd_if.sv | 26 ++
 rtl/fifo_burst_rd.sv | 91 +++++++++
 2 files changed

// File: rtl/fifo_burst_rd_if.sv
// Upstream FWFT FIFO read port plus the downstream framed stream of fifo_burst_rd.
// The master modport is the burst reader's view; slave is the FIFO/sink side.
interface fifo_burst_rd_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic [AW:0]   fifo_rd_space;
    logic          fifo_rd_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_sof;
    logic          m_last;

    modport master (
        input  fifo_dout, fifo_empty, fifo_rd_space, m_ready,
        output fifo_rd_en, m_data, m_valid, m_sof, m_last
    );

    modport slave (
        output fifo_dout, fifo_empty, fifo_rd_space, m_ready,
        input  fifo_rd_en, m_data, m_valid, m_sof, m_last
    );
endinterface

// File: rtl/fifo_burst_rd.sv
// Waits until a full burst is readable from an FWFT FIFO, then emits a header beat
// followed by BURST_LEN payload beats streamed straight from the FIFO head.
module fifo_burst_rd #(
    parameter int            DW        = 8,
    parameter int            AW        = 8,
    parameter int            BURST_LEN = 16,
    parameter logic [DW-1:0] HDR_WORD  = DW'(8'hA5)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fifo_burst_rd_if.master        bus,
    output logic                   busy,
    output logic [15:0]            burst_cnt
);
    localparam int             BCW       = $clog2(BURST_LEN) + 1;
    localparam logic [AW:0]    LEN_SPACE = (AW + 1)'(BURST_LEN);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } state_t;

    state_t         r_state;
    logic [BCW-1:0] r_beat;
    logic [15:0]    r_burst_cnt;

    logic w_in_data;
    logic w_valid;
    logic w_last;
    logic w_xfer;

    // Payload handshake is combinational so the FIFO head reaches the sink with no added latency.
    assign w_in_data = (r_state == DATA);
    assign w_valid   = (r_state == HDR) || (w_in_data && !bus.fifo_empty);
    assign w_last    = w_in_data && !bus.fifo_empty && (r_beat == LAST_BEAT);
    assign w_xfer    = w_in_data && !bus.fifo_empty && bus.m_ready;

    always_comb begin
        // NOTE: default first, so states that leave m_data alone cannot infer a latch.
        bus.m_data = '0;
        unique case (r_state)
            HDR:     bus.m_data = HDR_WORD;
            DATA:    bus.m_data = bus.fifo_dout;
            default: bus.m_data = '0;
        endcase
    end

    assign bus.m_valid    = w_valid;
    assign bus.m_sof      = (r_state == HDR);
    assign bus.m_last     = w_last;
    assign bus.fifo_rd_en = w_xfer;
    assign busy           = (r_state != IDLE);
    assign burst_cnt      = r_burst_cnt;

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_beat      <= '0;
            r_burst_cnt <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.fifo_rd_space >= LEN_SPACE) begin
                        r_state <= HDR;
                    end
                end
                HDR: begin
                    if (bus.m_ready) begin
                        r_state <= DATA;
                        r_beat  <= '0;
                    end
                end
                DATA: begin
                    // An empty FIFO only pauses the burst; it is never abandoned here.
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state     <= IDLE;
                            r_burst_cnt <= r_burst_cnt + 16'd1;
                        end else begin
                            r_beat <= r_beat + BCW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
